if_ctrl: RTL and testbench

Instruction-fetch controller sitting between the memory port and the instruction queue. Sequences word fetches from a program counter, pushes each returned instruction with its PC into the queue, and respects queue back-pressure. On a branch/jump redirect it flushes the queue and discards any in-flight or buffered fetch. One outstanding memory request at a time.

---
 rtl/if_ctrl_pkg.sv | 34 +++
 rtl/if_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_if_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/if_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// if_ctrl_pkg
// Shared constants and types for the instruction-fetch controller.
//   DATA_BUS / ADDR_BUS : instruction word and address widths
//   RESET_PC_DFLT       : default reset program counter
//   PC_STEP             : byte distance between consecutive instruction words
//   if_state_e          : fetch FSM state codes (2-bit)
//   word_align()        : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package if_ctrl_pkg;

  localparam int DATA_BUS = 32;
  localparam int ADDR_BUS = 32;

  localparam logic [ADDR_BUS-1:0] RESET_PC_DFLT = 32'h0000_0000;
  localparam logic [ADDR_BUS-1:0] PC_STEP       = 32'h0000_0004;

  // IDLE : nothing outstanding, waiting for queue room to issue
  // REQ  : request presented to memory, waiting for ack
  // WAIT : request accepted, waiting for read data
  // HOLD : read data parked in the buffer because the queue was full
  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [ADDR_BUS-1:0] word_align(input logic [ADDR_BUS-1:0] addr);
    return addr & ~(ADDR_BUS'(3));
  endfunction

endpackage

// File: rtl/if_ctrl.sv
// -----------------------------------------------------------------------------
// if_ctrl
// Instruction-fetch controller between a single-outstanding memory port and
// the instruction queue. Fetches words sequentially from the program counter,
// pushes each returned word with its PC into the queue, honours queue
// back-pressure, and on a redirect flushes the queue and discards any fetch
// that is in flight or parked in the hold buffer.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   rdy              : global enable; when low every register holds
//   jumpEn_i/jumpPc_i: redirect pulse and target (low two bits ignored)
//   qFull_i          : queue full
//   qAddEn_o/qAddData_o/qAddPc_o : queue push strobe, word, word PC
//   qClr_o           : queue flush pulse (cycle after a redirect)
//   memReq_o/memAddr_o/memAck_i  : fetch request handshake
//   memValid_i/memData_i         : fetch read data
// All outputs are registered.
// -----------------------------------------------------------------------------
module if_ctrl
  import if_ctrl_pkg::*;
#(
  parameter logic [ADDR_BUS-1:0] RESET_PC = RESET_PC_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                jumpEn_i,
  input  logic [ADDR_BUS-1:0] jumpPc_i,
  input  logic                qFull_i,
  output logic                qAddEn_o,
  output logic [DATA_BUS-1:0] qAddData_o,
  output logic [ADDR_BUS-1:0] qAddPc_o,
  output logic                qClr_o,
  output logic                memReq_o,
  output logic [ADDR_BUS-1:0] memAddr_o,
  input  logic                memAck_i,
  input  logic                memValid_i,
  input  logic [DATA_BUS-1:0] memData_i
);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  if_state_e           state_reg,      state_next;
  logic [ADDR_BUS-1:0] pc_reg,         pc_next;        // next address to fetch
  logic [ADDR_BUS-1:0] fpc_reg,        fpc_next;       // PC of the in-flight fetch
  logic                drop_reg,       drop_next;      // in-flight response is stale
  logic [DATA_BUS-1:0] buf_data_reg,   buf_data_next;
  logic [ADDR_BUS-1:0] buf_pc_reg,     buf_pc_next;

  // Registered outputs
  logic                q_add_en_reg,   q_add_en_next;
  logic [DATA_BUS-1:0] q_add_data_reg, q_add_data_next;
  logic [ADDR_BUS-1:0] q_add_pc_reg,   q_add_pc_next;
  logic                q_clr_reg,      q_clr_next;
  logic                mem_req_reg,    mem_req_next;
  logic [ADDR_BUS-1:0] mem_addr_reg,   mem_addr_next;

  // Decisions shared between the next-state and output processes
  logic issue;     // start a new fetch at pc_reg this cycle
  logic push_mem;  // push the word arriving on memData_i
  logic push_buf;  // push the word parked in the hold buffer

  logic [ADDR_BUS-1:0] jump_target;
  assign jump_target = word_align(jumpPc_i);

  // ---------------------------------------------------------------------------
  // Process 1: state register. Reset wins over rdy so a stuck-low enable
  // cannot block initialisation.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IF_IDLE;
      pc_reg         <= RESET_PC;
      fpc_reg        <= RESET_PC;
      drop_reg       <= 1'b0;
      buf_data_reg   <= '0;
      buf_pc_reg     <= '0;
      q_add_en_reg   <= 1'b0;
      q_add_data_reg <= '0;
      q_add_pc_reg   <= '0;
      q_clr_reg      <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= RESET_PC;
    end else if (rdy) begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      fpc_reg        <= fpc_next;
      drop_reg       <= drop_next;
      buf_data_reg   <= buf_data_next;
      buf_pc_reg     <= buf_pc_next;
      q_add_en_reg   <= q_add_en_next;
      q_add_data_reg <= q_add_data_next;
      q_add_pc_reg   <= q_add_pc_next;
      q_clr_reg      <= q_clr_next;
      mem_req_reg    <= mem_req_next;
      mem_addr_reg   <= mem_addr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic. A redirect outranks every other event in the
  // same cycle; the only thing it cannot undo is an ack already given, which is
  // why REQ+ack+jump lands in WAIT with drop set.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    fpc_next      = fpc_reg;
    drop_next     = drop_reg;
    buf_data_next = buf_data_reg;
    buf_pc_next   = buf_pc_reg;
    issue         = 1'b0;
    push_mem      = 1'b0;
    push_buf      = 1'b0;

    case (state_reg)
      IF_IDLE: begin
        if (jumpEn_i) begin
          pc_next = jump_target;
        end else if (!qFull_i) begin
          state_next = IF_REQ;
          fpc_next   = pc_reg;
          issue      = 1'b1;
        end
      end

      IF_REQ: begin
        // memValid_i is deliberately ignored here: only a response to an
        // acknowledged request is meaningful, and after reset a stale one
        // may still show up.
        if (jumpEn_i) begin
          pc_next = jump_target;
          if (memAck_i) begin
            state_next = IF_WAIT;
            drop_next  = 1'b1;
          end else begin
            state_next = IF_IDLE;
          end
        end else if (memAck_i) begin
          state_next = IF_WAIT;
          pc_next    = pc_reg + PC_STEP;  // wraps modulo 2^32
        end
      end

      IF_WAIT: begin
        if (jumpEn_i) begin
          pc_next = jump_target;
          if (memValid_i) begin
            // Response arrives with the redirect: consume and discard it.
            state_next = IF_IDLE;
            drop_next  = 1'b0;
          end else begin
            drop_next  = 1'b1;
          end
        end else if (memValid_i) begin
          if (drop_reg) begin
            state_next = IF_IDLE;
            drop_next  = 1'b0;
          end else if (!qFull_i) begin
            // Push and chain straight into the next fetch.
            push_mem   = 1'b1;
            state_next = IF_REQ;
            fpc_next   = pc_reg;
            issue      = 1'b1;
          end else begin
            state_next    = IF_HOLD;
            buf_data_next = memData_i;
            buf_pc_next   = fpc_reg;
          end
        end
      end

      IF_HOLD: begin
        if (jumpEn_i) begin
          pc_next    = jump_target;
          state_next = IF_IDLE;  // parked word is simply abandoned
        end else if (!qFull_i) begin
          push_buf   = 1'b1;
          state_next = IF_IDLE;
        end
      end

      default: begin
        state_next = IF_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: output logic (values loaded into the output registers).
  // Push data/PC hold their last value between strobes.
  // ---------------------------------------------------------------------------
  always_comb begin
    q_add_en_next   = push_mem | push_buf;
    q_add_data_next = q_add_data_reg;
    q_add_pc_next   = q_add_pc_reg;
    if (push_mem) begin
      q_add_data_next = memData_i;
      q_add_pc_next   = fpc_reg;
    end else if (push_buf) begin
      q_add_data_next = buf_data_reg;
      q_add_pc_next   = buf_pc_reg;
    end

    q_clr_next    = jumpEn_i;
    // The request line mirrors residence in REQ; the address only moves on
    // issue so it stays stable for the whole request and beyond.
    mem_req_next  = (state_next == IF_REQ);
    mem_addr_next = issue ? pc_reg : mem_addr_reg;
  end

  assign qAddEn_o   = q_add_en_reg;
  assign qAddData_o = q_add_data_reg;
  assign qAddPc_o   = q_add_pc_reg;
  assign qClr_o     = q_clr_reg;
  assign memReq_o   = mem_req_reg;
  assign memAddr_o  = mem_addr_reg;

endmodule

// File: tb/tb_if_ctrl.sv
// -----------------------------------------------------------------------------
// tb_if_ctrl
// Directed, table-driven bench for if_ctrl (RESET_PC = 0x100). Each table row
// holds the inputs for one clock edge and the registered outputs expected
// right after that edge. A short hand-written sequence afterwards covers a
// redirect while a word is parked in HOLD and a variable-latency response.
// -----------------------------------------------------------------------------
module tb_if_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, jumpEn_i, qFull_i, memAck_i, memValid_i;
  logic [31:0] jumpPc_i, memData_i;
  logic        qAddEn_o, qClr_o, memReq_o;
  logic [31:0] qAddData_o, qAddPc_o, memAddr_o;

  always #5 clk = ~clk;

  if_ctrl #(.RESET_PC(32'h0000_0100)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .jumpEn_i   (jumpEn_i),
    .jumpPc_i   (jumpPc_i),
    .qFull_i    (qFull_i),
    .qAddEn_o   (qAddEn_o),
    .qAddData_o (qAddData_o),
    .qAddPc_o   (qAddPc_o),
    .qClr_o     (qClr_o),
    .memReq_o   (memReq_o),
    .memAddr_o  (memAddr_o),
    .memAck_i   (memAck_i),
    .memValid_i (memValid_i),
    .memData_i  (memData_i)
  );

  typedef struct {
    logic        rst, rdy, jmp;
    logic [31:0] jpc;
    logic        qf, ack, vld;
    logic [31:0] dat;
    logic        e_en;
    logic [31:0] e_data, e_pc;
    logic        e_clr, e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, rd, j, input logic [31:0] jp,
                              input logic qf, ak, vl, input logic [31:0] d,
                              input logic en, input logic [31:0] od, op,
                              input logic c, q, input logic [31:0] a);
    vec_t v;
    v.rst = r;  v.rdy = rd; v.jmp = j;  v.jpc = jp;
    v.qf  = qf; v.ack = ak; v.vld = vl; v.dat = d;
    v.e_en = en; v.e_data = od; v.e_pc = op;
    v.e_clr = c; v.e_req = q; v.e_addr = a;
    return v;
  endfunction

  // Drive one cycle of inputs on the falling edge, let the rising edge
  // sample them, and return just after that edge.
  task automatic apply(input logic r, rd, j, input logic [31:0] jp,
                       input logic qf, ak, vl, input logic [31:0] d);
    @(negedge clk);
    rst = r; rdy = rd; jumpEn_i = j; jumpPc_i = jp;
    qFull_i = qf; memAck_i = ak; memValid_i = vl; memData_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [98:0] got, want;
    bit          seen;

    rst = 1'b1; rdy = 1'b1; jumpEn_i = 1'b0; jumpPc_i = '0;
    qFull_i = 1'b0; memAck_i = 1'b0; memValid_i = 1'b0; memData_i = '0;

    //             rst rdy jmp jpc           qf ack vld data         | en data          pc            clr req addr
    // reset, then zero-wait fetch of 0x100 and push
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h0,        32'h0,        0, 0, 32'h100));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h0,        32'h0,        0, 1, 32'h100));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'h0,        32'h0,        0, 0, 32'h100));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 32'hA000_0100,  1, 32'hA000_0100, 32'h100,     0, 1, 32'h104));
    // 0x104 returns while full: parked in HOLD for three cycles, then pushed
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'hA000_0100, 32'h100,     0, 0, 32'h104));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 1, 32'hA000_0104,  0, 32'hA000_0100, 32'h100,     0, 0, 32'h104));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 0, 32'h0,          0, 32'hA000_0100, 32'h100,     0, 0, 32'h104));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 0, 32'h0,          0, 32'hA000_0100, 32'h100,     0, 0, 32'h104));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,          1, 32'hA000_0104, 32'h104,     0, 0, 32'h104));
    // resume at 0x108
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'hA000_0104, 32'h104,     0, 1, 32'h108));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'hA000_0104, 32'h104,     0, 0, 32'h108));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 32'hA000_0108,  1, 32'hA000_0108, 32'h108,     0, 1, 32'h10C));
    // redirect to 0x2003 while waiting on 0x10C: flush, drop, refetch 0x2000
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'hA000_0108, 32'h108,     0, 0, 32'h10C));
    vecs.push_back(mk(0, 1, 1, 32'h2003,     0, 0, 0, 32'h0,          0, 32'hA000_0108, 32'h108,     1, 0, 32'h10C));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 32'hDEAD_010C,  0, 32'hA000_0108, 32'h108,     0, 0, 32'h10C));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'hA000_0108, 32'h108,     0, 1, 32'h2000));
    // redirect in the same cycle as ack: acked response dropped
    vecs.push_back(mk(0, 1, 1, 32'h3000,     0, 1, 0, 32'h0,          0, 32'hA000_0108, 32'h108,     1, 0, 32'h2000));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 32'hDEAD_2000,  0, 32'hA000_0108, 32'h108,     0, 0, 32'h2000));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'hA000_0108, 32'h108,     0, 1, 32'h3000));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'hA000_0108, 32'h108,     0, 0, 32'h3000));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 32'hB000_3000,  1, 32'hB000_3000, 32'h3000,    0, 1, 32'h3004));
    // rdy low for 4 cycles in WAIT with valid held: nothing moves
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'hB000_3000, 32'h3000,    0, 0, 32'h3004));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 1, 32'hB000_3004,  0, 32'hB000_3000, 32'h3000,    0, 0, 32'h3004));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 32'hB000_3004,  1, 32'hB000_3004, 32'h3004,    0, 1, 32'h3008));
    // redirect to the top word, then check the PC wraps to 0
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'hB000_3004, 32'h3004,    0, 0, 32'h3008));
    vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 32'h0,         0, 32'hB000_3004, 32'h3004,    1, 0, 32'h3008));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 32'hDEAD_3008,  0, 32'hB000_3004, 32'h3004,    0, 0, 32'h3008));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'hB000_3004, 32'h3004,    0, 1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'hB000_3004, 32'h3004,    0, 0, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 32'hC000_FFFC,  1, 32'hC000_FFFC, 32'hFFFF_FFFC, 0, 1, 32'h0));
    // reset mid-WAIT; a late response in IDLE is ignored
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'hC000_FFFC, 32'hFFFF_FFFC, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h0,        32'h0,        0, 0, 32'h100));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 1, 32'hDEAD_0000,  0, 32'h0,        32'h0,        0, 0, 32'h100));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h0,        32'h0,        0, 1, 32'h100));
    // redirect in REQ without ack: request withdrawn
    vecs.push_back(mk(0, 1, 1, 32'h4000,     0, 0, 0, 32'h0,          0, 32'h0,        32'h0,        1, 0, 32'h100));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h0,        32'h0,        0, 1, 32'h4000));
    // redirect in WAIT together with valid: response discarded, straight to IDLE
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'h0,        32'h0,        0, 0, 32'h4000));
    vecs.push_back(mk(0, 1, 1, 32'h5000,     0, 0, 1, 32'hDEAD_4000,  0, 32'h0,        32'h0,        1, 0, 32'h4000));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h0,        32'h0,        0, 1, 32'h5000));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,          0, 32'h0,        32'h0,        0, 0, 32'h5000));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 32'hD000_5000,  1, 32'hD000_5000, 32'h5000,    0, 1, 32'h5004));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].rdy, vecs[i].jmp, vecs[i].jpc,
            vecs[i].qf, vecs[i].ack, vecs[i].vld, vecs[i].dat);
      got  = {qAddEn_o, qAddData_o, qAddPc_o, qClr_o, memReq_o, memAddr_o};
      want = {vecs[i].e_en, vecs[i].e_data, vecs[i].e_pc,
              vecs[i].e_clr, vecs[i].e_req, vecs[i].e_addr};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL vec%0d: got en=%b data=%h pc=%h clr=%b req=%b addr=%h expected en=%b data=%h pc=%h clr=%b req=%b addr=%h",
                 i, qAddEn_o, qAddData_o, qAddPc_o, qClr_o, memReq_o, memAddr_o,
                 want[98], want[97:66], want[65:34], want[33], want[32], want[31:0]);
      end else begin
        $display("vec%0d: en=%b data=%h pc=%h clr=%b req=%b addr=%h",
                 i, qAddEn_o, qAddData_o, qAddPc_o, qClr_o, memReq_o, memAddr_o);
      end
    end

    // Hand sequence: park a word in HOLD, redirect, then the new target must
    // be fetched and the parked word must never reach the queue.
    apply(0, 1, 0, 32'h0, 0, 1, 0, 32'h0);                  // ack 0x5004
    check("hs_ack_req_low", {31'h0, memReq_o}, 32'h0);
    apply(0, 1, 0, 32'h0, 1, 0, 1, 32'hE000_5004);          // full -> HOLD
    check("hs_hold_no_push", {31'h0, qAddEn_o}, 32'h0);
    apply(0, 1, 1, 32'h6001, 1, 0, 0, 32'h0);               // redirect in HOLD
    check("hs_hold_jump_clr", {31'h0, qClr_o}, 32'h1);
    check("hs_hold_jump_no_push", {31'h0, qAddEn_o}, 32'h0);
    apply(0, 1, 0, 32'h0, 0, 0, 0, 32'h0);
    check("hs_issue_req", {31'h0, memReq_o}, 32'h1);
    check("hs_issue_addr", memAddr_o, 32'h6000);
    apply(0, 1, 0, 32'h0, 0, 1, 0, 32'h0);                  // ack
    apply(0, 1, 0, 32'h0, 0, 0, 0, 32'h0);                  // memory latency
    apply(0, 1, 0, 32'h0, 0, 0, 0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      apply(0, 1, 0, 32'h0, 0, 0, (i == 0), (i == 0) ? 32'hF000_6000 : 32'h0);
      seen = qAddEn_o;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL hs_push_timeout: got no push expected push of pc 00006000");
    end else begin
      check("hs_push_data", qAddData_o, 32'hF000_6000);
      check("hs_push_pc", qAddPc_o, 32'h6000);
      check("hs_next_addr", memAddr_o, 32'h6004);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
